// File: rtl/byte_word_packer.sv
// byte_word_packer: packs BYTES serial bytes into a word, buffered in a 2-entry FIFO.
// Optional idle-timeout discard of partial words when PACKER_TIMEOUT_EN is defined.
module byte_word_packer #(
  parameter int BYTES = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic               src_clk,
  input  logic               async_reset_n,
  input  logic [7:0]         in_byte,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [8*BYTES-1:0] out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [7:0]         drop_count,
  output logic               busy
);
  localparam int W = 8 * BYTES;
  localparam int CW = $clog2(BYTES);
  logic [W-9:0] acc;
  logic [W-1:0] mem [2];
  logic [W-1:0] word;
  logic [CW-1:0] cnt;
  logic [1:0] fcnt;
  logic wp, rp, last, beat, push, pop, drop;
  assign last = cnt == CW'(BYTES - 1);
  assign in_ready = !(last && fcnt == 2'd2);
  assign beat = in_valid && in_ready;
  assign push = beat && last;
  assign pop = out_valid && out_ready;
  assign word = {acc, in_byte};
  assign out_valid = fcnt != 2'd0;
  assign out_data = mem[rp];
  assign busy = (cnt != '0) || (fcnt != 2'd0);
`ifdef PACKER_TIMEOUT_EN
  localparam int IW = $clog2(TIMEOUT_CYCLES);
  logic [IW-1:0] idle;
  logic [7:0] drops;
  assign drop = !beat && cnt != '0 && idle == IW'(TIMEOUT_CYCLES - 1);
  assign drop_count = drops;
  always_ff @(posedge src_clk or negedge async_reset_n)
    if (!async_reset_n) begin
      idle <= '0;
      drops <= '0;
    end else begin
      idle <= (beat || cnt == '0 || drop) ? '0 : idle + 1'b1;
      drops <= drops + 8'(drop && drops != 8'hFF);
    end
`else
  assign drop = 1'b0;
  assign drop_count = '0;
`endif
  always_ff @(posedge src_clk or negedge async_reset_n)
    if (!async_reset_n) begin
      acc <= '0;
      cnt <= '0;
      fcnt <= '0;
      wp <= 1'b0;
      rp <= 1'b0;
      mem[0] <= '0;
      mem[1] <= '0;
    end else begin
      cnt <= drop ? '0 : beat ? (last ? '0 : cnt + 1'b1) : cnt;
      if (beat) acc <= word[W-9:0];
      if (push) begin
        mem[wp] <= word;
        wp <= ~wp;
      end
      if (pop) rp <= ~rp;
      fcnt <= fcnt + 2'(push) - 2'(pop);
    end
endmodule

// File: tb/tb_byte_word_packer.sv
// tb_byte_word_packer: directed and scoreboard checks for byte_word_packer (BYTES=4).
module tb_byte_word_packer;
  logic src_clk = 1'b0;
  logic async_reset_n;
  logic [7:0] in_byte;
  logic in_valid, in_ready, out_valid, out_ready, busy;
  logic [31:0] out_data;
  logic [7:0] drop_count;
  int pass = 0, total = 0;

  byte_word_packer #(.BYTES(4), .TIMEOUT_CYCLES(16)) dut (
    .src_clk(src_clk), .async_reset_n(async_reset_n), .in_byte(in_byte),
    .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .drop_count(drop_count), .busy(busy)
  );

  always #5 src_clk = ~src_clk;

  task automatic step(input int n = 1);
    repeat (n) @(posedge src_clk);
    #1;
  endtask

  task automatic test_reset;
    async_reset_n = 1'b0;
    in_valid = 1'b0;
    in_byte = 8'h00;
    out_ready = 1'b0;
    #12;
    total++;
    if ({in_ready, out_valid, out_data, drop_count, busy} !== {1'b1, 1'b0, 32'h0, 8'h0, 1'b0})
      $display("FAIL reset: ir=%b ov=%b od=%h dc=%0d busy=%b, want 1 0 0 0 0",
               in_ready, out_valid, out_data, drop_count, busy);
    else pass++;
    step();
    async_reset_n = 1'b1;
    step();
  endtask

  task automatic test_basic;
    logic [7:0] b [4];
    b = '{8'h11, 8'h22, 8'h33, 8'h44};
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_byte = b[i];
      in_valid = 1'b1;
      step();
      total++;
      if (out_valid !== (i == 3)) $display("FAIL basic_valid byte %0d: got %b want %b", i, out_valid, i == 3);
      else pass++;
    end
    in_valid = 1'b0;
    total++;
    if (out_data !== 32'h11223344) $display("FAIL basic_data: got %h want 11223344", out_data);
    else pass++;
    step();
    total++;
    if (out_valid !== 1'b0 || busy !== 1'b0) $display("FAIL basic_pulse: ov=%b busy=%b want 0 0", out_valid, busy);
    else pass++;
  endtask

  task automatic test_backpressure;
    out_ready = 1'b0;
    for (int i = 1; i <= 11; i++) begin
      total++;
      if (in_ready !== 1'b1) $display("FAIL bp_ready_before byte %0d: got %b want 1", i, in_ready);
      else pass++;
      in_byte = 8'(i);
      in_valid = 1'b1;
      step();
    end
    total++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 32'h01020304)
      $display("FAIL bp_full: ir=%b ov=%b od=%h want 0 1 01020304", in_ready, out_valid, out_data);
    else pass++;
    in_byte = 8'h0C;
    step(3);
    total++;
    if (in_ready !== 1'b0 || out_data !== 32'h01020304)
      $display("FAIL bp_stall: ir=%b od=%h want 0 01020304", in_ready, out_data);
    else pass++;
    out_ready = 1'b1;
    step();
    total++;
    if (in_ready !== 1'b1 || out_data !== 32'h05060708)
      $display("FAIL bp_word2: ir=%b od=%h want 1 05060708", in_ready, out_data);
    else pass++;
    step();
    in_valid = 1'b0;
    total++;
    if (out_valid !== 1'b1 || out_data !== 32'h090A0B0C)
      $display("FAIL bp_word3: ov=%b od=%h want 1 090a0b0c", out_valid, out_data);
    else pass++;
    step();
    total++;
    if (out_valid !== 1'b0 || busy !== 1'b0) $display("FAIL bp_drain: ov=%b busy=%b want 0 0", out_valid, busy);
    else pass++;
  endtask

  task automatic test_back_to_back;
    logic [31:0] q [$];
    logic [31:0] macc = '0;
    int mcnt = 0, mfcnt = 0, nb = 0, got = 0, bad = 0, overlap = 0;
    logic exp_ir, beat, pop, push;
    for (int c = 0; c < 5000 && got < 64; c++) begin
      in_valid = (nb < 256) && ($urandom % 4 != 0);
      in_byte = 8'(nb * 7 + 3);
      out_ready = 1'($urandom % 2);
      exp_ir = !(mcnt == 3 && mfcnt == 2);
      if (in_ready !== exp_ir || out_valid !== (mfcnt != 0)) begin
        bad++;
        if (bad < 5) $display("FAIL rand_ctrl cycle %0d: ir=%b ov=%b want %b %b", c, in_ready, out_valid, exp_ir, mfcnt != 0);
      end
      beat = in_valid && exp_ir;
      pop = (mfcnt != 0) && out_ready;
      push = beat && mcnt == 3;
      if (push && pop && mfcnt == 1) overlap++;
      if (pop) begin
        total++;
        if (out_data !== q[0]) $display("FAIL rand_data word %0d: got %h want %h", got, out_data, q[0]);
        else pass++;
        void'(q.pop_front());
        got++;
      end
      if (beat) begin
        macc = {macc[23:0], in_byte};
        nb++;
        if (mcnt == 3) begin
          q.push_back(macc);
          mcnt = 0;
        end else mcnt++;
      end
      mfcnt = mfcnt + int'(push) - int'(pop);
      step();
    end
    in_valid = 1'b0;
    total++;
    if (got !== 64 || bad !== 0) $display("FAIL rand_summary: words=%0d ctrl_errs=%0d want 64 0", got, bad);
    else pass++;
    total++;
    if (overlap == 0) $display("FAIL rand_overlap: push/pop at fcnt=1 seen %0d times, want >0", overlap);
    else pass++;
    out_ready = 1'b1;
    step();
  endtask

  task automatic test_reset_mid;
    out_ready = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_byte = 8'(8'h40 + i);
      step();
    end
    in_valid = 1'b0;
    total++;
    if (out_valid !== 1'b1 || busy !== 1'b1 || in_ready !== 1'b1)
      $display("FAIL rmid_pre: ov=%b busy=%b ir=%b want 1 1 1", out_valid, busy, in_ready);
    else pass++;
    #1 async_reset_n = 1'b0;
    #1;
    total++;
    if ({in_ready, out_valid, out_data, drop_count, busy} !== {1'b1, 1'b0, 32'h0, 8'h0, 1'b0})
      $display("FAIL rmid_async: ir=%b ov=%b od=%h dc=%0d busy=%b want 1 0 0 0 0",
               in_ready, out_valid, out_data, drop_count, busy);
    else pass++;
    step();
    async_reset_n = 1'b1;
    out_ready = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_byte = 8'(8'hA1 + i);
      step();
    end
    in_valid = 1'b0;
    total++;
    if (out_valid !== 1'b1 || out_data !== 32'hA1A2A3A4)
      $display("FAIL rmid_word: ov=%b od=%h want 1 a1a2a3a4", out_valid, out_data);
    else pass++;
    step();
  endtask

`ifdef PACKER_TIMEOUT_EN
  task automatic test_timeout;
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_byte = 8'hAA;
    step();
    in_byte = 8'hBB;
    step();
    in_valid = 1'b0;
    step(15);
    total++;
    if (busy !== 1'b1 || drop_count !== 8'd0) $display("FAIL to_early: busy=%b dc=%0d want 1 0", busy, drop_count);
    else pass++;
    step();
    total++;
    if (busy !== 1'b0 || drop_count !== 8'd1) $display("FAIL to_drop: busy=%b dc=%0d want 0 1", busy, drop_count);
    else pass++;
    in_valid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      in_byte = 8'(i);
      step();
    end
    in_valid = 1'b0;
    total++;
    if (out_valid !== 1'b1 || out_data !== 32'h01020304)
      $display("FAIL to_word: ov=%b od=%h want 1 01020304", out_valid, out_data);
    else pass++;
    step();
    in_valid = 1'b1;
    in_byte = 8'hCC;
    step();
    in_valid = 1'b0;
    step(15);
    in_valid = 1'b1;
    in_byte = 8'hDD;
    step();
    in_valid = 1'b0;
    total++;
    if (busy !== 1'b1 || drop_count !== 8'd1) $display("FAIL to_beat_wins: busy=%b dc=%0d want 1 1", busy, drop_count);
    else pass++;
    step(16);
    total++;
    if (busy !== 1'b0 || drop_count !== 8'd2) $display("FAIL to_second: busy=%b dc=%0d want 0 2", busy, drop_count);
    else pass++;
    for (int r = 0; r < 300; r++) begin
      in_valid = 1'b1;
      in_byte = 8'(r);
      step();
      in_valid = 1'b0;
      step(16);
    end
    total++;
    if (drop_count !== 8'd255 || busy !== 1'b0) $display("FAIL to_saturate: dc=%0d busy=%b want 255 0", drop_count, busy);
    else pass++;
  endtask
`else
  task automatic test_hold;
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_byte = 8'hDE;
    step();
    in_byte = 8'hAD;
    step();
    in_valid = 1'b0;
    step(5000);
    total++;
    if (busy !== 1'b1 || out_valid !== 1'b0) $display("FAIL hold_partial: busy=%b ov=%b want 1 0", busy, out_valid);
    else pass++;
    in_valid = 1'b1;
    in_byte = 8'hBE;
    step();
    in_byte = 8'hEF;
    step();
    in_valid = 1'b0;
    total++;
    if (out_valid !== 1'b1 || out_data !== 32'hDEADBEEF || drop_count !== 8'd0)
      $display("FAIL hold_word: ov=%b od=%h dc=%0d want 1 deadbeef 0", out_valid, out_data, drop_count);
    else pass++;
    step();
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_back_to_back();
`ifdef PACKER_TIMEOUT_EN
    test_timeout();
`else
    test_hold();
`endif
    test_reset_mid();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
